// File: rtl/fft_frame_sched.sv
// fft_frame_sched: round-robin time-multiplexing of NUM_CH real-sample channels onto one fft_core,
// one frame (2*FFT_SIZE input beats, FFT_SIZE tagged output beats) in flight at a time.
module fft_frame_sched #(
    parameter int NUM_CH     = 4,
    parameter int FFT_SIZE   = 1024,
    parameter int DATA_WIDTH = 16,
    localparam int CH_W      = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(2 * FFT_SIZE)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [NUM_CH-1:0]            ch_mask_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    output logic [NUM_CH-1:0]            ch_ready_o,
    output logic [DATA_WIDTH-1:0]        core_adc_data_o,
    output logic                         core_adc_valid_o,
    input  logic                         core_adc_ready_i,
    input  logic [2*DATA_WIDTH-1:0]      core_out_data_i,
    input  logic                         core_out_valid_i,
    output logic                         core_out_ready_o,
    output logic [2*DATA_WIDTH-1:0]      out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [CH_W-1:0]              out_ch_o,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         frame_done_o
);
    typedef enum logic [1:0] {IDLE, ARB, FEED, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  grant_q, rr_ptr_q, arb_ch;
    logic [CH_W:0]    scan;
    logic             arb_hit, in_fire, out_fire, in_last, out_last;
    logic [NUM_CH-1:0] req;
    logic [CNT_W-1:0] in_cnt_q, out_cnt_q;

    assign req      = ch_valid_i & ch_mask_i;
    assign in_fire  = core_adc_valid_o & core_adc_ready_i;
    assign out_fire = out_valid_o & out_ready_i;
    assign in_last  = in_cnt_q == CNT_W'(2 * FFT_SIZE - 1);
    assign out_last = out_cnt_q == CNT_W'(FFT_SIZE - 1);

    // Scan offsets high-to-low so the closest requester at or after rr_ptr wins.
    always_comb begin
        arb_ch  = '0;
        arb_hit = 1'b0;
        scan    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scan = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            scan = scan >= (CH_W+1)'(NUM_CH) ? scan - (CH_W+1)'(NUM_CH) : scan;
            if (req[scan[CH_W-1:0]]) begin
                arb_ch  = scan[CH_W-1:0];
                arb_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_o <= out_fire & out_last;
            if (state_q == ARB && arb_hit) grant_q <= arb_ch;
            if (in_fire) in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
            if (out_fire) out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
            if (out_fire && out_last) rr_ptr_q <= grant_q == CH_W'(NUM_CH - 1) ? '0 : grant_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = enable_i && |req ? ARB : IDLE;
            ARB:   state_d = arb_hit ? FEED : IDLE;
            FEED:  state_d = in_fire && in_last ? DRAIN : FEED;
            DRAIN: state_d = out_fire && out_last ? IDLE : DRAIN;
        endcase
    end

    always_comb begin
        core_adc_data_o  = state_q == FEED ? ch_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        core_adc_valid_o = state_q == FEED && ch_valid_i[grant_q];
        ch_ready_o       = state_q == FEED && core_adc_ready_i ? NUM_CH'(1) << grant_q : '0;
        out_data_o       = state_q == DRAIN ? core_out_data_i : '0;
        out_valid_o      = state_q == DRAIN && core_out_valid_i;
        core_out_ready_o = state_q == DRAIN && out_ready_i;
        out_last_o       = out_valid_o && out_last;
        out_ch_o         = grant_q;
        busy_o           = state_q != IDLE;
    end
endmodule
